data_cache_ctrl: RTL and testbench

//  Responder for the memory-stage data request interface (read_cmd/write_cmd/byte_access/address).

---
 rtl/data_cache_ctrl.sv | 167 ++++++++++++++++
 tb/tb_data_cache_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_cache_ctrl.sv
// rtl/data_cache_ctrl.sv - direct-mapped write-back write-allocate data cache controller
module data_cache_ctrl #(
    parameter int INDEX_BITS = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         read_cmd,
    input  logic         write_cmd,
    input  logic         byte_access,
    input  logic [31:0]  address,
    input  logic [31:0]  write_data,
    output logic [31:0]  read_data,
    output logic         stall,
    output logic         mem_req,
    output logic         mem_we,
    output logic [31:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 28 - INDEX_BITS;

    typedef enum logic [1:0] {IDLE, EVICT, FILL} state_t;

    state_t             state_q, state_d;
    logic [127:0]       data_q [LINES];
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [LINES-1:0]   valid_q, valid_d;
    logic [LINES-1:0]   dirty_q, dirty_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [127:0]       mem_wdata_q, mem_wdata_d;
    logic [27:0]        line_addr_q, line_addr_d;

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_W-1:0]      tag;
    logic [INDEX_BITS-1:0] line_idx;
    logic [TAG_W-1:0]      line_tag;
    logic [127:0]          cur_line;
    logic [127:0]          wline;
    logic [31:0]           rword;
    logic [7:0]            rbyte;
    logic                  req;
    logic                  hit;
    logic                  store;
    logic                  install;

    assign idx      = address[4 +: INDEX_BITS];
    assign tag      = address[31 -: TAG_W];
    assign line_idx = line_addr_q[INDEX_BITS-1:0];
    assign line_tag = line_addr_q[27 -: TAG_W];
    assign cur_line = data_q[idx];
    // Gating with reset keeps the outputs quiet and the arrays untouched while held in reset.
    assign req      = reset & (read_cmd | write_cmd);
    assign hit      = valid_q[idx] && (tag_q[idx] == tag);
    assign stall    = req & ((state_q != IDLE) | ~hit);
    assign rword    = cur_line[{address[3:2], 5'b0} +: 32];
    assign rbyte    = cur_line[{address[3:0], 3'b0} +: 8];

    assign read_data = (req && read_cmd && !write_cmd && !stall)
                     ? (byte_access ? {24'b0, rbyte} : rword) : 32'b0;

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    always_comb begin
        wline = cur_line;
        if (byte_access) begin
            wline[{address[3:0], 3'b0} +: 8] = write_data[7:0];
        end else begin
            wline[{address[3:2], 5'b0} +: 32] = write_data;
        end
    end

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        line_addr_d = line_addr_q;
        store       = 1'b0;
        install     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req && hit) begin
                    if (write_cmd) begin
                        store        = 1'b1;
                        dirty_d[idx] = 1'b1;
                    end
                end else if (req) begin
                    // Latch the missing line so a dropped request still completes coherently.
                    line_addr_d = address[31:4];
                    mem_req_d   = 1'b1;
                    if (valid_q[idx] && dirty_q[idx]) begin
                        state_d     = EVICT;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {tag_q[idx], idx, 4'b0};
                        mem_wdata_d = cur_line;
                    end else begin
                        state_d    = FILL;
                        mem_we_d   = 1'b0;
                        mem_addr_d = {address[31:4], 4'b0};
                    end
                end
            end
            EVICT: begin
                if (mem_ready) begin
                    dirty_d[line_idx] = 1'b0;
                    state_d           = FILL;
                    mem_we_d          = 1'b0;
                    mem_addr_d        = {line_addr_q, 4'b0};
                end
            end
            FILL: begin
                if (mem_ready) begin
                    install           = 1'b1;
                    valid_d[line_idx] = 1'b1;
                    dirty_d[line_idx] = 1'b0;
                    state_d           = IDLE;
                    mem_req_d         = 1'b0;
                    mem_we_d          = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            dirty_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'b0;
            mem_wdata_q <= 128'b0;
            line_addr_q <= 28'b0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            line_addr_q <= line_addr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (install) begin
            data_q[line_idx] <= mem_rdata;
            tag_q[line_idx]  <= line_tag;
        end else if (store) begin
            data_q[idx] <= wline;
        end
    end

endmodule

// File: tb/tb_data_cache_ctrl.sv
// tb/tb_data_cache_ctrl.sv - directed self-checking bench for data_cache_ctrl
module tb_data_cache_ctrl;

    logic         clock = 1'b0;
    logic         reset;
    logic         read_cmd, write_cmd, byte_access;
    logic [31:0]  address, write_data, read_data;
    logic         stall, mem_req, mem_we, mem_ready;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata, mem_rdata;

    int pass_cnt = 0;
    int total    = 0;

    int           st_cycles;
    logic         ev_seen;
    logic [31:0]  ev_addr, fill_addr;
    logic [127:0] ev_wdata;

    localparam logic [127:0] LINE_40  = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11223344};
    localparam logic [127:0] LINE_140 = {32'hA3A3A3A3, 32'hCAFEF00D, 32'h77777777, 32'h66666666};
    localparam logic [127:0] LINE_80  = {32'h0D0D0D0D, 32'h0C0C0C0C, 32'h0B0B0B0B, 32'h0A0A0A0A};

    data_cache_ctrl #(.INDEX_BITS(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .read_cmd    (read_cmd),
        .write_cmd   (write_cmd),
        .byte_access (byte_access),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .stall       (stall),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic b,
                         input logic [31:0] a, input logic [31:0] d);
        read_cmd    = r;
        write_cmd   = w;
        byte_access = b;
        address     = a;
        write_data  = d;
    endtask

    // Memory answers on every 6th cycle that mem_req is high (a 5-cycle memory).
    task automatic run_miss(input logic [127:0] line);
        int cnt;
        cnt       = 0;
        st_cycles = 0;
        ev_seen   = 1'b0;
        ev_addr   = 32'b0;
        ev_wdata  = 128'b0;
        fill_addr = 32'hFFFFFFFF;
        for (int i = 0; i < 40; i++) begin
            mem_ready = 1'b0;
            if (mem_req) begin
                cnt++;
                if (mem_we && !ev_seen) begin
                    ev_seen  = 1'b1;
                    ev_addr  = mem_addr;
                    ev_wdata = mem_wdata;
                end
                if (!mem_we && fill_addr == 32'hFFFFFFFF) fill_addr = mem_addr;
                mem_rdata = line;
                mem_ready = (cnt % 6 == 0);
            end
            #1;
            if (!stall) break;
            st_cycles++;
            step();
        end
        mem_ready = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = 128'b0;
        drive(1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
        step();
        step();
        chk("rst_stall", stall, 0);
        chk("rst_rdata", read_data, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);

        // cold read miss
        step();
        reset = 1'b1;
        #1;
        chk("t1_stall_now", stall, 1);
        chk("t1_req_not_yet", mem_req, 0);
        run_miss(LINE_40);
        chk("t1_no_evict", ev_seen, 0);
        chk("t1_fill_addr", fill_addr, 32'h40);
        chk("t1_stall_cycles", st_cycles, 7);
        chk("t1_rdata", read_data, 32'h11223344);
        chk("t1_req_dropped", mem_req, 0);

        // byte store hit, then loads
        step();
        drive(1'b0, 1'b1, 1'b1, 32'h41, 32'hFFFFFFAB);
        #1;
        chk("t2_sb_stall", stall, 0);
        chk("t2_sb_rdata", read_data, 0);
        step();
        drive(1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
        #1;
        chk("t2_lw_stall", stall, 0);
        chk("t2_lw_rdata", read_data, 32'h1122AB44);
        step();
        drive(1'b1, 1'b0, 1'b1, 32'h41, 32'h0);
        #1;
        chk("t2_lb41", read_data, 32'h000000AB);
        step();
        drive(1'b1, 1'b0, 1'b1, 32'h43, 32'h0);
        #1;
        chk("t2_lb43", read_data, 32'h00000011);
        step();
        drive(1'b0, 1'b0, 1'b0, 32'h40, 32'h0);
        #1;
        chk("idle_stall", stall, 0);

        // dirty eviction
        step();
        drive(1'b1, 1'b0, 1'b0, 32'h140, 32'h0);
        run_miss(LINE_140);
        chk("t3_evict_seen", ev_seen, 1);
        chk("t3_evict_addr", ev_addr, 32'h40);
        chk("t3_evict_word0", ev_wdata[31:0], 32'h1122AB44);
        chk("t3_evict_word3", ev_wdata[127:96], 32'h44444444);
        chk("t3_fill_addr", fill_addr, 32'h140);
        chk("t3_stall_cycles", st_cycles, 13);
        chk("t3_rdata", read_data, 32'h66666666);

        // back-to-back hits
        step();
        drive(1'b0, 1'b1, 1'b0, 32'h144, 32'hDEADBEEF);
        #1;
        chk("t4_sw_stall", stall, 0);
        step();
        drive(1'b1, 1'b0, 1'b0, 32'h144, 32'h0);
        #1;
        chk("t4_lw144_stall", stall, 0);
        chk("t4_lw144", read_data, 32'hDEADBEEF);
        step();
        drive(1'b1, 1'b0, 1'b0, 32'h14B, 32'h0);
        #1;
        chk("t4_lw148_stall", stall, 0);
        chk("t4_lw148", read_data, 32'hCAFEF00D);

        // read and write together act as a store
        step();
        drive(1'b1, 1'b1, 1'b0, 32'h14C, 32'h55);
        #1;
        chk("t6_stall", stall, 0);
        chk("t6_rdata", read_data, 0);
        step();
        drive(1'b1, 1'b0, 1'b0, 32'h14C, 32'h0);
        #1;
        chk("t6_readback", read_data, 32'h55);

        // reset during fill
        step();
        drive(1'b1, 1'b0, 1'b0, 32'h80, 32'h0);
        #1;
        chk("t5_stall", stall, 1);
        step();
        chk("t5_fill_req", mem_req, 1);
        chk("t5_fill_addr", mem_addr, 32'h80);
        step();
        reset = 1'b0;
        #1;
        chk("t5_req_cut", mem_req, 0);
        chk("t5_rst_stall", stall, 0);
        step();
        reset     = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h80, 32'h0);
        mem_rdata = LINE_80;
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        chk("t5_late_ready", mem_req, 0);
        drive(1'b1, 1'b0, 1'b0, 32'h80, 32'h0);
        #1;
        chk("t5_misses_again", stall, 1);
        run_miss(LINE_80);
        chk("t5_refill_addr", fill_addr, 32'h80);
        chk("t5_refill_cycles", st_cycles, 7);
        chk("t5_refill_rdata", read_data, 32'h0A0A0A0A);
        step();
        drive(1'b1, 1'b0, 1'b0, 32'h140, 32'h0);
        #1;
        chk("t5_valid_cleared", stall, 1);
        run_miss(LINE_140);
        chk("t5_clean_after_rst", ev_seen, 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
